// File: rtl/lsu.sv
// lsu: load/store unit between the execute stage and dmem, with store-lane replication.
// Build option LSU_MISALIGN_EN: split misaligned accesses into byte beats; otherwise they fault.
module lsu #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  busy,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic [31:0]           misalign_count,
    output logic                  mem_we,
    output logic [1:0]            mem_write_size,
    output logic [1:0]            mem_read_size,
    output logic                  mem_unsigned,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wd,
    input  logic [31:0]           mem_rd
);
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic        size_legal;
    logic        misaligned;
    logic        idle;
    logic        accept;
    logic [31:0] wd_rep;
    logic [31:0] count_reg;

    assign size_legal = (req_size != 2'b11);
    assign misaligned = req_valid &&
                        ((req_size == SIZE_HALF && req_addr[0]) ||
                         (req_size == SIZE_WORD && req_addr[1:0] != 2'b00));
    assign accept     = idle && misaligned;

    // dmem picks its byte lane from the address, so every lane carries the data
    always_comb begin
        case (req_size)
            SIZE_BYTE: wd_rep = {4{req_wdata[7:0]}};
            SIZE_HALF: wd_rep = {2{req_wdata[15:0]}};
            default:   wd_rep = req_wdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (accept && count_reg != 32'hFFFF_FFFF) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign misalign_count = count_reg;

`ifdef LSU_MISALIGN_EN
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SPLIT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]            state_reg;
    logic [1:0]            k_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  we_reg;
    logic                  half_reg;
    logic                  unsigned_reg;
    logic [31:0]           wdata_reg;
    logic [31:0]           buf_reg;
    logic [7:0]            wbyte [4];
    logic [31:0]           load_ext;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wbyte[gi] = wdata_reg[8*gi +: 8];
        end
    endgenerate

    assign idle       = (state_reg == ST_IDLE);
    assign resp_fault = 1'b0;
    assign load_ext   = !half_reg    ? buf_reg :
                        unsigned_reg ? {16'h0000, buf_reg[15:0]} :
                                       {{16{buf_reg[15]}}, buf_reg[15:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            k_reg        <= 2'd0;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            half_reg     <= 1'b0;
            unsigned_reg <= 1'b0;
            wdata_reg    <= '0;
            buf_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (misaligned) begin
                        state_reg    <= ST_SPLIT;
                        k_reg        <= 2'd0;
                        addr_reg     <= req_addr;
                        we_reg       <= req_we;
                        half_reg     <= (req_size == SIZE_HALF);
                        unsigned_reg <= req_unsigned;
                        wdata_reg    <= req_wdata;
                    end
                end
                ST_SPLIT: begin
                    if (!we_reg) begin
                        buf_reg[{k_reg, 3'b000} +: 8] <= mem_rd[7:0];
                    end
                    if (k_reg == (half_reg ? 2'd1 : 2'd3)) begin
                        state_reg <= ST_DONE;
                    end else begin
                        k_reg <= k_reg + 2'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy           = 1'b0;
        resp_valid     = req_valid && size_legal;
        resp_rdata     = req_we ? 32'h0 : mem_rd;
        mem_we         = req_valid && req_we && size_legal;
        mem_write_size = req_size;
        mem_read_size  = req_size;
        mem_unsigned   = req_unsigned;
        mem_addr       = req_addr;
        mem_wd         = wd_rep;
        case (state_reg)
            ST_SPLIT: begin
                busy           = 1'b1;
                resp_valid     = 1'b0;
                resp_rdata     = 32'h0;
                mem_we         = we_reg;
                mem_write_size = SIZE_BYTE;
                mem_read_size  = SIZE_BYTE;
                mem_unsigned   = 1'b1;
                mem_addr       = addr_reg + ADDR_WIDTH'(k_reg);
                mem_wd         = {4{wbyte[k_reg]}};
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                resp_rdata = we_reg ? 32'h0 : load_ext;
                mem_we     = 1'b0;
            end
            default: begin
                if (misaligned) begin
                    busy       = 1'b1;
                    resp_valid = 1'b0;
                    resp_rdata = 32'h0;
                    mem_we     = 1'b0;
                end
            end
        endcase
    end
`else
    assign idle = 1'b1;

    always_comb begin
        busy           = 1'b0;
        resp_fault     = misaligned;
        resp_valid     = req_valid && size_legal;
        resp_rdata     = (req_we || misaligned) ? 32'h0 : mem_rd;
        mem_we         = req_valid && req_we && size_legal && !misaligned;
        mem_write_size = req_size;
        mem_read_size  = req_size;
        mem_unsigned   = req_unsigned;
        mem_addr       = req_addr;
        mem_wd         = wd_rep;
    end
`endif

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed table plus randomized accesses against a byte-array model of memory.
// A small dmem model answers the DUT; expectations come from an independent reference memory.
module tb_lsu;
`ifdef LSU_MISALIGN_EN
    localparam bit SPLIT_BUILD = 1'b1;
`else
    localparam bit SPLIT_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [11:0] req_addr = 12'h000;
    logic [31:0] req_wdata = 32'h0;
    logic        busy, resp_valid, resp_fault, mem_we, mem_unsigned;
    logic [31:0] resp_rdata, misalign_count, mem_wd, mem_rd;
    logic [1:0]  mem_write_size, mem_read_size;
    logic [11:0] mem_addr;

    always #5 clk = ~clk;

    lsu #(.ADDR_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .misalign_count(misalign_count), .mem_we(mem_we),
        .mem_write_size(mem_write_size), .mem_read_size(mem_read_size),
        .mem_unsigned(mem_unsigned), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    // dmem stand-in: combinational read, lane-selected byte writes, write log
    logic [7:0]  mem [4096];
    logic        mem_clear = 1'b0;
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = 12'h0;
    logic [7:0]  poke_data = 8'h0;
    logic [11:0] log_addr [4096];
    logic [7:0]  log_data [4096];
    int          log_n = 0;
    logic [11:0] a1, a2, a3, wa;
    logic [1:0]  wl;
    logic [31:0] rd_word;
    int          wn;

    assign a1 = mem_addr + 12'd1;
    assign a2 = mem_addr + 12'd2;
    assign a3 = mem_addr + 12'd3;
    assign rd_word = {mem[a3], mem[a2], mem[a1], mem[mem_addr]};

    always_comb begin
        case (mem_read_size)
            2'b00:   mem_rd = mem_unsigned ? {24'h0, rd_word[7:0]} : {{24{rd_word[7]}}, rd_word[7:0]};
            2'b01:   mem_rd = mem_unsigned ? {16'h0, rd_word[15:0]} : {{16{rd_word[15]}}, rd_word[15:0]};
            default: mem_rd = rd_word;
        endcase
    end

    initial begin
        forever begin
            @(posedge clk);
            if (mem_clear) begin
                for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
            end else if (poke_en) begin
                mem[poke_addr] = poke_data;
            end else if (mem_we) begin
                wn = (mem_write_size == 2'b00) ? 1 : (mem_write_size == 2'b01) ? 2 :
                     (mem_write_size == 2'b10) ? 4 : 0;
                for (int i = 0; i < wn; i++) begin
                    wa = mem_addr + 12'(i);
                    wl = mem_addr[1:0] + 2'(i);
                    mem[wa] = mem_wd[{wl, 3'b000} +: 8];
                    log_addr[log_n % 4096] = wa;
                    log_data[log_n % 4096] = mem_wd[{wl, 3'b000} +: 8];
                    log_n++;
                end
            end
        end
    end

    // reference model
    logic [7:0]  ref_mem [4096];
    logic [31:0] model_count = 32'h0;
    int          errors = 0;
    int          checks = 0;
    int          txn = 0;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [11:0] addr, input logic [1:0] size,
                                                input logic uns);
        int n;
        logic [31:0] v;
        n = nbytes(size);
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(addr) + i) % 4096];
        if (!uns && n < 4 && v[8*n-1]) begin
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_rep(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (size == 2'b00) r[8*i +: 8] = d[7:0];
            if (size == 2'b01) r[8*i +: 8] = d[8*(i%2) +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (txn %0d): got %08h want %08h", name, txn, got, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input int exp_stall, input logic exp_fault);
        int n, stall, start, nb, exp_w;
        logic mis, got, fault_q;
        logic [31:0] rd_q, wd_q;
        logic [11:0] beats [8];
        n = nbytes(size);
        mis = (int'(addr) % n) != 0;
        start = log_n; stall = 0; nb = 0; got = 1'b0; rd_q = 32'h0; wd_q = 32'h0; fault_q = 1'b0;
        txn++;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (busy) begin
                stall++;
                if (mem_read_size == 2'b00 && nb < 8) begin
                    beats[nb] = mem_addr;
                    nb++;
                end
            end
            if (resp_valid) begin
                got = 1'b1; rd_q = resp_rdata; fault_q = resp_fault; wd_q = mem_wd;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        $display("txn %0d: we=%0d size=%0d uns=%0d addr=%03h wd=%08h rdata=%08h stall=%0d fault=%0d",
                 txn, we, size, uns, addr, wd, rd_q, stall, fault_q);
        check("resp_seen", 32'(got), 32'd1);
        check("resp_rdata", rd_q, exp_rd);
        check("stall_cycles", 32'(stall), 32'(exp_stall));
        check("resp_fault", 32'(fault_q), 32'(exp_fault));
        if (we && !mis) check("mem_wd_lanes", wd_q, model_rep(size, wd));
`ifdef LSU_MISALIGN_EN
        if (mis) begin
            check("beat_count", 32'(nb), 32'(n));
            for (int i = 0; i < nb && i < n; i++) check("beat_addr", 32'(beats[i]), 32'(addr + 12'(i)));
        end
`endif
        exp_w = (we && (SPLIT_BUILD || !mis)) ? n : 0;
        check("write_count", 32'(log_n - start), 32'(exp_w));
        for (int i = 0; i < exp_w && i < (log_n - start); i++) begin
            check("write_addr", 32'(log_addr[(start + i) % 4096]), 32'(addr + 12'(i)));
            check("write_data", 32'(log_data[(start + i) % 4096]), 32'(wd[8*i +: 8]));
        end
        for (int i = 0; i < exp_w; i++) ref_mem[(int'(addr) + i) % 4096] = wd[8*i +: 8];
        if (mis && model_count != 32'hFFFF_FFFF) model_count++;
        check("misalign_count", misalign_count, model_count);
    endtask

    typedef struct {
        logic        poke;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_stall;
        logic        exp_fault;
    } vec_t;

    vec_t tbl [32];
    int   nt = 0;

    task automatic add(input logic we, input logic [1:0] size, input logic uns, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int stall, input logic fault);
        tbl[nt] = '{1'b0, we, size, uns, addr, wd, rd, stall, fault};
        nt++;
    endtask

    task automatic add_poke(input logic [11:0] addr, input logic [7:0] d);
        tbl[nt] = '{1'b1, 1'b0, 2'b00, 1'b0, addr, {24'h0, d}, 32'h0, 0, 1'b0};
        nt++;
    endtask

    logic        r_we, r_uns, r_mis, e_fault;
    logic [1:0]  r_size;
    logic [11:0] r_addr;
    logic [31:0] r_wd, e_rd;
    int          e_stall, rst_start, exp_rst_w, bad;

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        rst = 1'b1;
        mem_clear = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_clear = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_fault", 32'(resp_fault), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_count", misalign_count, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_resp_valid", 32'(resp_valid), 32'd0);

        // directed vectors: we, size, uns, addr, wdata, expected rdata, stall cycles, fault
        add(1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 32'h0, 0, 0);
        add(0, 2'b10, 0, 12'h010, 32'h0, 32'hDEADBEEF, 0, 0);
        add(0, 2'b01, 0, 12'h010, 32'h0, 32'hFFFFBEEF, 0, 0);
        add(0, 2'b01, 1, 12'h010, 32'h0, 32'h0000BEEF, 0, 0);
        add(1, 2'b00, 0, 12'h013, 32'h1234565A, 32'h0, 0, 0);
        add(0, 2'b00, 1, 12'h013, 32'h0, 32'h0000005A, 0, 0);
        add(0, 2'b00, 0, 12'h012, 32'h0, 32'hFFFFFFAD, 0, 0);
        add(1, 2'b01, 0, 12'h016, 32'hABCD1234, 32'h0, 0, 0);
        add(0, 2'b10, 0, 12'h014, 32'h0, 32'h12340000, 0, 0);
        add_poke(12'h001, 8'h11);
        add_poke(12'h002, 8'h22);
        add_poke(12'h003, 8'h33);
        add_poke(12'h004, 8'h44);
        add(0, 2'b10, 0, 12'h001, 32'h0, SPLIT_BUILD ? 32'h44332211 : 32'h0, SPLIT_BUILD ? 5 : 0, !SPLIT_BUILD);
        add_poke(12'h003, 8'h80);
        add_poke(12'h004, 8'hFF);
        add(0, 2'b01, 0, 12'h003, 32'h0, SPLIT_BUILD ? 32'hFFFFFF80 : 32'h0, SPLIT_BUILD ? 3 : 0, !SPLIT_BUILD);
        add(0, 2'b01, 1, 12'h003, 32'h0, SPLIT_BUILD ? 32'h0000FF80 : 32'h0, SPLIT_BUILD ? 3 : 0, !SPLIT_BUILD);
        add(1, 2'b10, 0, 12'hFFE, 32'hA1B2C3D4, 32'h0, SPLIT_BUILD ? 5 : 0, !SPLIT_BUILD);
        add(0, 2'b10, 0, 12'hFFE, 32'h0, SPLIT_BUILD ? 32'hA1B2C3D4 : 32'h0, SPLIT_BUILD ? 5 : 0, !SPLIT_BUILD);
        add(0, 2'b10, 0, 12'h002, 32'h0, SPLIT_BUILD ? 32'h00FF8022 : 32'h0, SPLIT_BUILD ? 5 : 0, !SPLIT_BUILD);
        add(0, 2'b00, 0, 12'h003, 32'h0, 32'hFFFFFF80, 0, 0);
        add(0, 2'b00, 1, 12'hFFF, 32'h0, SPLIT_BUILD ? 32'h000000C3 : 32'h0, 0, 0);

        for (int i = 0; i < nt; i++) begin
            if (tbl[i].poke) poke(tbl[i].addr, tbl[i].wd[7:0]);
            else access(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wd,
                        tbl[i].exp_rd, tbl[i].exp_stall, tbl[i].exp_fault);
        end

        // illegal size: no write and no count
        txn++;
        rst_start = log_n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_addr = 12'h031; req_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("size11_mem_we", 32'(mem_we), 32'd0);
        check("size11_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 req_valid = 1'b0;
        check("size11_writes", 32'(log_n - rst_start), 32'd0);
        check("size11_count", misalign_count, model_count);
        $display("txn %0d: illegal size store addr=031", txn);

        // reset during a misaligned store after its second beat
        txn++;
        rst_start = log_n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 12'h021; req_wdata = 32'h11223344;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_count", misalign_count, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_rst_w = SPLIT_BUILD ? 2 : 0;
        check("midrst_writes", 32'(log_n - rst_start), 32'(exp_rst_w));
        for (int i = 0; i < exp_rst_w && i < (log_n - rst_start); i++) begin
            check("midrst_addr", 32'(log_addr[(rst_start + i) % 4096]), 32'h021 + 32'(i));
            check("midrst_data", 32'(log_data[(rst_start + i) % 4096]), 32'h44 - 32'(i * 8'h11));
        end
        for (int i = 0; i < exp_rst_w; i++) ref_mem[12'h021 + i] = 8'(8'h44 - i * 8'h11);
        model_count = 32'h0;
        check("midrst_idle_busy", 32'(busy), 32'd0);
        $display("txn %0d: reset during misaligned store at 021", txn);

        // randomized accesses against the reference model
        for (int t = 0; t < 150; t++) begin
            r_we   = 1'($urandom % 2);
            r_uns  = 1'($urandom % 2);
            r_size = 2'($urandom_range(0, 2));
            r_addr = ($urandom_range(0, 7) == 0) ? 12'(4092 + $urandom_range(0, 3))
                                                 : 12'($urandom_range(0, 63));
            r_wd   = $urandom;
            r_mis  = (int'(r_addr) % nbytes(r_size)) != 0;
            e_fault = !SPLIT_BUILD && r_mis;
            e_stall = (SPLIT_BUILD && r_mis) ? nbytes(r_size) + 1 : 0;
            e_rd    = (r_we || e_fault) ? 32'h0 : model_load(r_addr, r_size, r_uns);
            access(r_we, r_size, r_uns, r_addr, r_wd, e_rd, e_stall, e_fault);
        end

        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("memory_image", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
